// File: rtl/fetch_unit_pkg.sv
// Shared widths, branch-predictor constants and helper types for the fetch stage.
package fetch_unit_pkg;

    localparam int ADDR_WIDTH           = 16;
    localparam int INST_WIDTH           = 32;
    localparam int INSTRUCTION_ID_WIDTH = 8;
    localparam int BP_CTR_BITS          = 2;

    typedef logic [BP_CTR_BITS-1:0] bp_ctr_t;

    localparam bp_ctr_t BP_WEAK_TAKEN = bp_ctr_t'(2);
    localparam bp_ctr_t BP_CTR_MAX    = '1;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_PREDICT,
        NPC_HOLD,
        NPC_REDIRECT
    } npc_sel_e;

    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == BP_CTR_MAX) ? ctr : ctr + bp_ctr_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - bp_ctr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs, instruction memory port, BTB training port and
// the sideband handed to if_id_register. master = fetch unit, slave = its environment.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ID_WIDTH = INSTRUCTION_ID_WIDTH
);
    logic                  stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_address;

    logic [ADDR_WIDTH-1:0] imem_address;
    logic [INST_WIDTH-1:0] imem_instruction;

    logic                  bp_update;
    logic [ADDR_WIDTH-1:0] bp_update_pc;
    logic                  bp_update_taken;
    logic [ADDR_WIDTH-1:0] bp_update_target;

    logic [INST_WIDTH-1:0] instruction_out;
    logic                  first_out;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  branch_taken_out;
    logic [ADDR_WIDTH-1:0] branch_taken_address_out;
    logic [ID_WIDTH-1:0]   id_out;

    modport master (
        input  stall, flush, flush_address, imem_instruction,
               bp_update, bp_update_pc, bp_update_taken, bp_update_target,
        output imem_address, instruction_out, first_out, pc_out,
               branch_taken_out, branch_taken_address_out, id_out
    );

    modport slave (
        output stall, flush, flush_address, imem_instruction,
               bp_update, bp_update_pc, bp_update_taken, bp_update_target,
        input  imem_address, instruction_out, first_out, pc_out,
               branch_taken_out, branch_taken_address_out, id_out
    );
endinterface

// File: rtl/fetch_unit_branch_target_buffer.sv
// Direct-mapped BTB of 2-bit saturating counters: combinational lookup, clocked update.
// The lookup always sees pre-edge state, so a same-index update shows up one cycle later.
module branch_target_buffer
    import fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                  o_predict_taken,
    output logic [ADDR_WIDTH-1:0] o_predict_target,
    input  logic                  i_update,
    input  logic [ADDR_WIDTH-1:0] i_update_pc,
    input  logic                  i_update_taken,
    input  logic [ADDR_WIDTH-1:0] i_update_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    logic                  r_valid  [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    bp_ctr_t               r_ctr    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;

    assign w_lk_idx = i_lookup_pc[IDX_W-1:0];
    assign w_lk_tag = i_lookup_pc[ADDR_WIDTH-1:IDX_W];
    assign w_up_idx = i_update_pc[IDX_W-1:0];
    assign w_up_tag = i_update_pc[ADDR_WIDTH-1:IDX_W];

    assign o_predict_taken  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag)
                              && (r_ctr[w_lk_idx] >= BP_WEAK_TAKEN);
    assign o_predict_target = o_predict_taken ? r_target[w_lk_idx] : '0;

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the whole array is reset on purpose -- "all entries invalid, ctr=0"
            // must hold immediately after reset, and a flop array (not SRAM) allows it.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (i_update) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= bp_ctr_next(r_ctr[w_up_idx], i_update_taken);
                if (i_update_taken) begin
                    r_target[w_up_idx] <= i_update_target;
                end
            end else if (i_update_taken) begin
                // Taken miss evicts whatever occupies the slot, entering at weakly taken.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_ctr[w_up_idx]    <= BP_WEAK_TAKEN;
                r_target[w_up_idx] <= i_update_target;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction id and first-flag registers plus the
// next-PC mux. All outputs are combinational from state, giving zero-cycle fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    BTB_ENTRIES = 16,
    parameter int                    ID_WIDTH    = INSTRUCTION_ID_WIDTH
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam logic [ID_WIDTH-1:0] ID_ONE = ID_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_first;

    logic                  w_pred_taken;
    logic [ADDR_WIDTH-1:0] w_pred_target;
    logic                  w_accept;
    npc_sel_e              w_npc_sel;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [ID_WIDTH-1:0]   w_next_id;

    branch_target_buffer #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk              (clk),
        .reset            (reset),
        .i_lookup_pc      (r_pc),
        .o_predict_taken  (w_pred_taken),
        .o_predict_target (w_pred_target),
        .i_update         (bus.bp_update),
        .i_update_pc      (bus.bp_update_pc),
        .i_update_taken   (bus.bp_update_taken),
        .i_update_target  (bus.bp_update_target)
    );

    assign w_accept = !bus.stall && !bus.flush;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_npc_sel = NPC_SEQ;
        if (bus.flush) begin
            w_npc_sel = NPC_REDIRECT;
        end else if (bus.stall) begin
            w_npc_sel = NPC_HOLD;
        end else if (w_pred_taken) begin
            w_npc_sel = NPC_PREDICT;
        end
    end

    always_comb begin
        w_next_pc = r_pc + 1'b1;
        unique case (w_npc_sel)
            NPC_REDIRECT: w_next_pc = bus.flush_address;
            NPC_HOLD:     w_next_pc = r_pc;
            NPC_PREDICT:  w_next_pc = w_pred_target;
            NPC_SEQ:      w_next_pc = r_pc + 1'b1;
            default:      w_next_pc = r_pc + 1'b1;
        endcase
    end

    // Id 0 marks bubbles downstream, so the counter wraps from all-ones back to 1.
    assign w_next_id = (r_id == '1) ? ID_ONE : r_id + ID_ONE;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_id    <= ID_ONE;
            r_first <= 1'b1;
        end else begin
            r_pc <= w_next_pc;
            if (w_accept) begin
                r_id    <= w_next_id;
                r_first <= 1'b0;
            end
        end
    end

    assign bus.imem_address             = r_pc;
    assign bus.pc_out                   = r_pc;
    assign bus.instruction_out          = bus.imem_instruction;
    assign bus.first_out                = r_first;
    assign bus.id_out                   = r_id;
    assign bus.branch_taken_out         = w_pred_taken;
    assign bus.branch_taken_address_out = w_pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, id-wrap and mid-operation
// reset sequences, then random traffic against a behavioural reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int                    ID_W     = 4;
    localparam int                    ENTRIES  = 16;
    localparam logic [ADDR_WIDTH-1:0] RST_PC   = 16'h0010;
    localparam int                    ID_MAX   = (1 << ID_W) - 1;
    localparam int                    ADDR_MOD = 1 << ADDR_WIDTH;

    logic clk;
    logic reset;

    fetch_unit_if #(.ID_WIDTH(ID_W)) bus ();

    fetch_unit #(
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (ENTRIES),
        .ID_WIDTH    (ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INST_WIDTH-1:0] imem_f(input logic [ADDR_WIDTH-1:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    assign bus.imem_instruction = imem_f(bus.imem_address);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] pc, input logic [3:0] id,
                                 input logic first, input logic taken, input logic [15:0] tgt);
        check({tag, ".pc_out"},       32'(bus.pc_out), 32'(pc));
        check({tag, ".imem_address"}, 32'(bus.imem_address), 32'(pc));
        check({tag, ".instruction"},  bus.instruction_out, imem_f(pc));
        check({tag, ".id_out"},       32'(bus.id_out), 32'(id));
        check({tag, ".first_out"},    32'(bus.first_out), 32'(first));
        check({tag, ".taken"},        32'(bus.branch_taken_out), 32'(taken));
        check({tag, ".target"},       32'(bus.branch_taken_address_out), 32'(tgt));
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit valid;
        int pc;
        int ctr;
        int target;
    } m_entry_t;

    m_entry_t m_btb [ENTRIES];
    int       m_pc;
    int       m_id;
    bit       m_first;

    task automatic m_reset();
        m_pc    = int'(RST_PC);
        m_id    = 1;
        m_first = 1'b1;
        for (int i = 0; i < ENTRIES; i++) m_btb[i] = '{1'b0, 0, 0, 0};
    endtask

    task automatic m_predict(input int pc, output bit t, output int tgt);
        m_entry_t e;
        e   = m_btb[pc % ENTRIES];
        t   = e.valid && e.pc == pc && e.ctr >= 2;
        tgt = t ? e.target : 0;
    endtask

    task automatic m_step(input bit s, input bit f, input int fa,
                          input bit u, input int up, input bit ut, input int utg);
        bit       t;
        int       tgt;
        m_entry_t e;
        m_predict(m_pc, t, tgt);
        if (f)       m_pc = fa;
        else if (s)  m_pc = m_pc;
        else if (t)  m_pc = tgt;
        else         m_pc = (m_pc + 1) % ADDR_MOD;
        if (!s && !f) begin
            m_id    = (m_id == ID_MAX) ? 1 : m_id + 1;
            m_first = 1'b0;
        end
        if (u) begin
            e = m_btb[up % ENTRIES];
            if (e.valid && e.pc == up) begin
                if (ut) begin
                    e.ctr    = (e.ctr < 3) ? e.ctr + 1 : 3;
                    e.target = utg;
                end else begin
                    e.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
                end
            end else if (ut) begin
                e = '{1'b1, up, 2, utg};
            end
            m_btb[up % ENTRIES] = e;
        end
    endtask

    task automatic check_model(input string tag);
        bit t;
        int tgt;
        m_predict(m_pc, t, tgt);
        check_outputs(tag, 16'(m_pc), 4'(m_id), m_first, t, 16'(tgt));
    endtask

    task automatic drive(input logic s, input logic f, input logic [15:0] fa,
                         input logic u, input logic [15:0] up, input logic ut, input logic [15:0] utg);
        bus.stall            = s;
        bus.flush            = f;
        bus.flush_address    = fa;
        bus.bp_update        = u;
        bus.bp_update_pc     = up;
        bus.bp_update_taken  = ut;
        bus.bp_update_target = utg;
        m_step(s, f, int'(fa), u, int'(up), ut, int'(utg));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        s;
        logic        f;
        logic [15:0] fa;
        logic        u;
        logic [15:0] up;
        logic        ut;
        logic [15:0] utg;
        logic [15:0] e_pc;
        logic [3:0]  e_id;
        logic        e_first;
        logic        e_taken;
        logic [15:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic f, input logic [15:0] fa,
                                input logic u, input logic [15:0] up, input logic ut,
                                input logic [15:0] utg, input logic [15:0] e_pc,
                                input logic [3:0] e_id, input logic e_first,
                                input logic e_taken, input logic [15:0] e_tgt);
        vec_t v;
        v = '{s, f, fa, u, up, ut, utg, e_pc, e_id, e_first, e_taken, e_tgt};
        return v;
    endfunction

    initial begin
        //              s     f     fa        u     up        ut    utg       pc        id    fst   tkn   tgt
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0010, 4'd1, 1'b1, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0011, 4'd2, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0012, 4'd3, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020, 4'd3, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020, 4'd3, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020, 4'd3, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0020, 4'd3, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0021, 4'd4, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0080, 4'd4, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 16'h0081, 4'd5, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0005, 4'd5, 1'b0, 1'b1, 16'h0040));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0040, 4'd6, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0041, 4'd7, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0040, 16'h0005, 4'd7, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0044, 16'h0006, 4'd8, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0060, 16'h0005, 4'd8, 1'b0, 1'b1, 16'h0044));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0015, 4'd8, 1'b0, 1'b1, 16'h0060));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0005, 4'd8, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0006, 4'd9, 1'b0, 1'b0, 16'h0000));

        reset = 1'b1;
        m_reset();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.flush_address = '0;
        bus.bp_update = 1'b0; bus.bp_update_pc = '0; bus.bp_update_taken = 1'b0; bus.bp_update_target = '0;
        #3;
        check_outputs("in_reset", RST_PC, 4'd1, 1'b1, 1'b0, 16'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        foreach (vecs[i]) begin
            check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_id, vecs[i].e_first,
                          vecs[i].e_taken, vecs[i].e_tgt);
            drive(vecs[i].s, vecs[i].f, vecs[i].fa, vecs[i].u, vecs[i].up, vecs[i].ut, vecs[i].utg);
            @(negedge clk);
            #1;
        end

        // Id wrap: state is now pc 0x07, id 10; eight accepted fetches cross 15 -> 1.
        for (int k = 0; k < 8; k++) begin
            check($sformatf("wrap%0d.id_out", k), 32'(bus.id_out), 32'(((10 + k - 1) % ID_MAX) + 1));
            check($sformatf("wrap%0d.pc_out", k), 32'(bus.pc_out), 32'(16'h0007 + k));
            idle();
            @(negedge clk);
            #1;
        end

        // Reset mid-operation with a redirect and a BTB allocation pending.
        drive(1'b0, 1'b1, 16'h0033, 1'b1, 16'h0007, 1'b1, 16'h0021);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("midrst", RST_PC, 4'd1, 1'b1, 1'b0, 16'h0);
        m_reset();
        @(negedge clk);
        bus.flush = 1'b0; bus.bp_update = 1'b0;
        reset = 1'b0;
        #1;
        check_model("post_rst");
        drive(1'b0, 1'b1, 16'h0007, 1'b0, 16'h0, 1'b0, 16'h0);
        @(negedge clk);
        #1;
        check_outputs("rst_drop_upd", 16'h0007, 4'd1, 1'b1, 1'b0, 16'h0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic        s, f, u, ut;
            logic [15:0] fa, up, utg;
            check_model($sformatf("rnd%0d", c));
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 9) == 0);
            fa  = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom_range(0, 63));
            u   = ($urandom_range(0, 4) < 2);
            up  = 16'($urandom_range(0, 63));
            ut  = 1'($urandom_range(0, 1));
            utg = 16'($urandom_range(0, 63));
            drive(s, f, fa, u, up, ut, utg);
            @(negedge clk);
            #1;
        end
        check_model("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
